// File: rtl/fp_move_pkg.sv
// Shared types for the FP move unit: op encoding, NaN-box pattern, queued result entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_move_pkg;

    typedef enum logic [1:0] {
        FMV_W_X = 2'b00,   // int -> FP, single (NaN-boxed)
        FMV_X_W = 2'b01,   // FP -> int, single (sign-extended)
        FMV_D_X = 2'b10,   // int -> FP, double
        FMV_X_D = 2'b11    // FP -> int, double
    } fp_move_op_e;

    // Upper half forced to ones when a single is written into a 64-bit FP register.
    localparam logic [63:0] NAN_BOX = 64'hFFFF_FFFF_0000_0000;

    // Entry data is sized for the widest legal configuration; the top trims it to OUT_W.
    typedef struct packed {
        logic [63:0] data;
        logic        to_fp;
        logic        illegal;
    } move_entry_t;

endpackage

// File: rtl/fp_move_fifo.sv
// Generic DEPTH-entry result FIFO with occupancy count, synchronous flush and EN-gated push/pop.
// Latency: a push at edge N is at the head after edge N when the FIFO was empty.
// Backpressure: pushes are dropped when full and pops ignored when empty; flush wins over both.
//
// Ports: CLK/RST clock and async active-low reset, EN freezes all state when low,
// flush clears, push/push_data write the tail, pop removes the head, head/count observe.
module fp_move_fifo
    import fp_move_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       EN,
    input  logic                       flush,
    input  logic                       push,
    input  move_entry_t                push_data,
    input  logic                       pop,
    output move_entry_t                head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    move_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;
    logic          do_flush;

    assign do_flush = EN && flush;
    assign push_ok  = EN && !flush && push && (count < CW'(DEPTH));
    assign pop_ok   = EN && !flush && pop && (count != '0);
    assign head     = mem[rd_ptr];

    // Storage needs no reset: the top masks the head whenever count is zero.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_move_unit.sv
// RISC-V FMV.{W.X,X.W,D.X,X.D} bit moves with NaN-boxing/sign-extension, queued for writeback.
// Latency: 1 cycle from accept to out_valid (empty queue); 1 op/cycle throughput.
// Backpressure: in_ready drops when the queue is full; no combinational path from out_ready.
//
// Ports: CLK, RST (async active-low), EN (freeze), flush (drop queued results),
// in_valid/in_ready/op/rs_int/rs_fp (issue side), out_valid/out_ready/out_data/out_to_fp/
// out_illegal (writeback side), count (entries queued).
module fp_move_unit
    import fp_move_pkg::*;
#(
    parameter  int XLEN  = 64,
    parameter  int FLEN  = 64,
    parameter  int DEPTH = 2,
    localparam int OUT_W = (XLEN > FLEN) ? XLEN : FLEN
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [XLEN-1:0]          rs_int,
    input  logic [FLEN-1:0]          rs_fp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_to_fp,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int  CW   = $clog2(DEPTH) + 1;
    // Double moves need both register files to be 64 bits wide.
    localparam bit  D_OK = (XLEN == 64) && (FLEN == 64);

    fp_move_op_e op_e;
    logic [63:0] int_src;
    logic [63:0] fp_src;
    move_entry_t result;
    move_entry_t head;
    logic        push;
    logic        pop;

    assign op_e    = fp_move_op_e'(op);
    assign int_src = 64'(rs_int);
    assign fp_src  = 64'(rs_fp);

    always_comb begin
        result       = '0;
        result.to_fp = ~op[0];
        case (op_e)
            FMV_W_X: begin
                result.data = {32'h0, int_src[31:0]};
                if (FLEN == 64) begin
                    result.data = result.data | NAN_BOX;
                end
            end
            FMV_X_W: begin
                result.data = {32'h0, fp_src[31:0]};
                if (XLEN == 64) begin
                    result.data[63:32] = {32{fp_src[31]}};
                end
            end
            FMV_D_X: begin
                if (D_OK) result.data    = int_src;
                else      result.illegal = 1'b1;
            end
            FMV_X_D: begin
                if (D_OK) result.data    = fp_src;
                else      result.illegal = 1'b1;
            end
            default: result = '0;
        endcase
    end

    // RST gates in_ready directly so nothing is offered while reset is held.
    assign in_ready  = RST && EN && !flush && (count < CW'(DEPTH));
    assign out_valid = EN && (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    fp_move_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .flush     (flush),
        .push      (push),
        .push_data (result),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_data    = out_valid ? head.data[OUT_W-1:0] : '0;
    assign out_to_fp   = out_valid && head.to_fp;
    assign out_illegal = out_valid && head.illegal;

endmodule

// File: tb/tb_fp_move_unit.sv
module tb_fp_move_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EN = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid2 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [63:0] rs_int = '0;
    logic [63:0] rs_fp = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_to_fp, out_illegal;
    logic [63:0] out_data;
    logic [1:0]  count;

    logic        b_in_ready, b_out_valid, b_out_to_fp, b_out_illegal;
    logic [63:0] b_out_data;
    logic [1:0]  b_count;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    fp_move_unit #(.XLEN(64), .FLEN(64), .DEPTH(2)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rs_int(rs_int), .rs_fp(rs_fp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_to_fp(out_to_fp), .out_illegal(out_illegal), .count(count)
    );

    // Narrow-FP instance: double moves are illegal, singles are not NaN-boxed.
    fp_move_unit #(.XLEN(64), .FLEN(32), .DEPTH(2)) dut_f32 (
        .CLK(CLK), .RST(RST), .EN(EN), .flush(flush),
        .in_valid(in_valid2), .in_ready(b_in_ready), .op(op),
        .rs_int(rs_int), .rs_fp(rs_fp[31:0]),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
        .out_to_fp(b_out_to_fp), .out_illegal(b_out_illegal), .count(b_count)
    );

    typedef struct {
        logic [63:0] d;
        logic        f;
        logic        i;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] ri;
        logic [63:0] rf;
        logic [63:0] exp_d;
        logic        exp_f;
        logic        exp_i;
    } vec_t;

    // Reference: the architectural meaning of each move, written from the ISA rules.
    function automatic exp_t ref_move(input logic [1:0] o, input logic [63:0] ri,
                                      input logic [63:0] rf, input int xl, input int fl);
        exp_t r;
        r.f = (o == 2'd0) || (o == 2'd2);
        r.i = 1'b0;
        r.d = '0;
        case (o)
            2'd0: r.d = (fl == 64) ? (ri & 64'hFFFF_FFFF) + 64'hFFFF_FFFF_0000_0000
                                   : (ri & 64'hFFFF_FFFF);
            2'd1: r.d = (xl == 64) ? 64'(longint'(int'(rf[31:0]))) : (rf & 64'hFFFF_FFFF);
            2'd2: begin
                if (xl == 64 && fl == 64) r.d = ri;
                else r.i = 1'b1;
            end
            default: begin
                if (xl == 64 && fl == 64) r.d = rf;
                else r.i = 1'b1;
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    vec_t vt[6];
    exp_t q[$];
    exp_t e;
    logic e_rdy, e_vld;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vt[0] = '{2'd0, 64'hC0CC_CCCC_C169_6042, 64'h0, 64'hFFFF_FFFF_C169_6042, 1'b1, 1'b0};
        vt[1] = '{2'd1, 64'h0, 64'hFFFF_FFFF_C0CC_CCCD, 64'hFFFF_FFFF_C0CC_CCCD, 1'b0, 1'b0};
        vt[2] = '{2'd1, 64'h0, 64'h0000_0000_40CC_CCCD, 64'h0000_0000_40CC_CCCD, 1'b0, 1'b0};
        vt[3] = '{2'd2, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0};
        vt[4] = '{2'd3, 64'h0, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0};
        vt[5] = '{2'd1, 64'h0, 64'hDEAD_BEEF_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0};

        // Reset state, with EN high so in_ready must be held low by RST alone.
        EN = 1'b1;
        #2;
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", out_data, 64'd0);
        chk("reset out_to_fp", 64'(out_to_fp), 64'd0);
        chk("reset out_illegal", 64'(out_illegal), 64'd0);
        chk("reset count", 64'(count), 64'd0);
        tick();
        tick();
        RST = 1'b1;
        tick();

        // Directed vectors, one at a time with out_ready high.
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            op = vt[k].op;
            rs_int = vt[k].ri;
            rs_fp = vt[k].rf;
            #1;
            chk($sformatf("vec%0d in_ready", k), 64'(in_ready), 64'd1);
            tick();
            in_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d out_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d out_data", k), out_data, vt[k].exp_d);
            chk($sformatf("vec%0d out_to_fp", k), 64'(out_to_fp), 64'(vt[k].exp_f));
            chk($sformatf("vec%0d out_illegal", k), 64'(out_illegal), 64'(vt[k].exp_i));
            tick();
            chk($sformatf("vec%0d drained", k), 64'(out_valid), 64'd0);
        end

        // Randomised traffic against the queue model.
        for (int c = 0; c < 400; c++) begin
            EN = ($urandom_range(7) != 0);
            flush = ($urandom_range(24) == 0);
            in_valid = $urandom_range(1);
            op = 2'($urandom_range(3));
            rs_int = {$urandom, $urandom};
            rs_fp = {$urandom, $urandom};
            out_ready = $urandom_range(1);
            #1;
            e_rdy = EN && !flush && (q.size() < 2);
            e_vld = EN && (q.size() != 0);
            chk("rnd in_ready", 64'(in_ready), 64'(e_rdy));
            chk("rnd out_valid", 64'(out_valid), 64'(e_vld));
            chk("rnd count", 64'(count), 64'(q.size()));
            chk("rnd out_data", out_data, e_vld ? q[0].d : 64'd0);
            chk("rnd out_to_fp", 64'(out_to_fp), e_vld ? 64'(q[0].f) : 64'd0);
            chk("rnd out_illegal", 64'(out_illegal), e_vld ? 64'(q[0].i) : 64'd0);
            if (EN && flush) begin
                q.delete();
            end else begin
                if (e_vld && out_ready) void'(q.pop_front());
                if (in_valid && e_rdy) q.push_back(ref_move(op, rs_int, rs_fp, 64, 64));
            end
            tick();
        end

        // Empty the queue before the directed corner cases.
        EN = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("pre flush count", 64'(count), 64'd0);

        // Backpressure: three D.X ops into a two-entry queue.
        in_valid = 1'b1; op = 2'd2; rs_int = 64'h1;
        tick();
        chk("bp count1", 64'(count), 64'd1);
        chk("bp ready1", 64'(in_ready), 64'd1);
        rs_int = 64'h2;
        tick();
        chk("bp count2", 64'(count), 64'd2);
        chk("bp ready full", 64'(in_ready), 64'd0);
        rs_int = 64'h3;
        tick();
        chk("bp held count", 64'(count), 64'd2);
        chk("bp head1", out_data, 64'h1);
        out_ready = 1'b1;
        tick();
        chk("bp head2", out_data, 64'h2);
        chk("bp ready after pop", 64'(in_ready), 64'd1);
        tick();
        chk("bp head3", out_data, 64'h3);
        chk("bp count pushpop", 64'(count), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("bp empty", 64'(out_valid), 64'd0);

        // Simultaneous push and pop at count 1, then flush with two queued.
        out_ready = 1'b0; in_valid = 1'b1; op = 2'd3; rs_fp = 64'hAAAA;
        tick();
        rs_fp = 64'hBBBB; out_ready = 1'b1;
        tick();
        chk("pp count", 64'(count), 64'd1);
        chk("pp head", out_data, 64'hBBBB);
        rs_fp = 64'hCCCC; out_ready = 1'b0;
        tick();
        chk("pp count2", 64'(count), 64'd2);
        chk("pp order", out_data, 64'hBBBB);
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush count", 64'(count), 64'd0);
        chk("flush out_valid", 64'(out_valid), 64'd0);

        // FLEN=32 instance: double moves illegal, single moves unboxed.
        in_valid2 = 1'b1; op = 2'd2; rs_int = 64'h1234_5678_9ABC_DEF0;
        tick();
        in_valid2 = 1'b0;
        chk("f32 dx valid", 64'(b_out_valid), 64'd1);
        chk("f32 dx illegal", 64'(b_out_illegal), 64'd1);
        chk("f32 dx data", b_out_data, 64'd0);
        chk("f32 dx to_fp", 64'(b_out_to_fp), 64'd1);
        tick();
        in_valid2 = 1'b1; op = 2'd0; rs_int = 64'hC0CC_CCCC_C169_6042;
        tick();
        in_valid2 = 1'b0;
        chk("f32 wx data", b_out_data, 64'h0000_0000_C169_6042);
        chk("f32 wx illegal", 64'(b_out_illegal), 64'd0);
        tick();
        in_valid2 = 1'b1; op = 2'd1; rs_fp = 64'h0000_0000_8000_0001;
        tick();
        in_valid2 = 1'b0;
        chk("f32 xw data", b_out_data, 64'hFFFF_FFFF_8000_0001);
        tick();
        in_valid2 = 1'b1; op = 2'd3;
        tick();
        in_valid2 = 1'b0;
        chk("f32 xd illegal", 64'(b_out_illegal), 64'd1);
        chk("f32 xd to_fp", 64'(b_out_to_fp), 64'd0);
        tick();

        // Reset mid-stream with two entries queued and EN toggled.
        out_ready = 1'b0; in_valid = 1'b1; op = 2'd2; rs_int = 64'h11;
        tick();
        rs_int = 64'h22;
        tick();
        in_valid = 1'b0; EN = 1'b0;
        #1;
        chk("en low out_valid", 64'(out_valid), 64'd0);
        chk("en low out_data", out_data, 64'd0);
        chk("en low count", 64'(count), 64'd2);
        chk("en low in_ready", 64'(in_ready), 64'd0);
        tick();
        EN = 1'b1;
        #1;
        chk("en high head", out_data, 64'h11);
        RST = 1'b0;
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        chk("rst count", 64'(count), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        #1;
        RST = 1'b1;
        tick();
        in_valid = 1'b1; op = 2'd2; rs_int = 64'h55;
        #1;
        chk("post rst empty", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("post rst valid", 64'(out_valid), 64'd1);
        chk("post rst data", out_data, 64'h55);
        chk("post rst count", 64'(count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_move_unit.md
# fp_move_unit

Parametrised, handshaked floating-point move unit for the Floating ALU. It executes the four RISC-V bit-pattern moves between the integer and FP register files: FMV.W.X, FMV.X.W, FMV.D.X and FMV.X.D. Single-precision results written to FP registers are NaN-boxed, and single-precision results written to integer registers are sign-extended. Results are queued in a small output FIFO with valid/ready flow control, so the unit decouples issue from FP/integer writeback.

## Interface
Parameters:
- XLEN, 64, integer register width (32 or 64)
- FLEN, 64, FP register width (32 or 64)
- DEPTH, 2, output FIFO entries (power of 2, ≥2)
- OUT_W (localparam), max(XLEN,FLEN), result width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- EN  in  1  unit enable; low freezes all state
- flush  in  1  synchronous clear of all queued results
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept
- op  in  2  00 FMV.W.X, 01 FMV.X.W, 10 FMV.D.X, 11 FMV.X.D
- rs_int  in  XLEN  integer source
- rs_fp  in  FLEN  FP source
- out_valid  out  1  head result available
- out_ready  in  1  consumer takes head
- out_data  out  OUT_W  result
- out_to_fp  out  1  result destined for FP file (op[0]==0)
- out_illegal  out  1  op unsupported at these widths
- count  out  $clog2(DEPTH)+1  entries queued

## Operation
- Accept when in_valid && in_ready. Result computed combinationally from the inputs and written into the FIFO tail in the same edge.
- FMV.W.X: {ones, rs_int[31:0]} on FLEN bits. Upper FLEN-32 bits are all 1 (NaN-box). Zero-extended to OUT_W.
- FMV.X.W: rs_fp[31:0] sign-extended to XLEN. Zero-extended to OUT_W.
- FMV.D.X: rs_int[63:0]. FMV.X.D: rs_fp[63:0].
- D ops when XLEN==32 or FLEN==32: data 0, out_illegal=1, entry still queued in order.
- Input NaN-box of rs_fp is not checked; the bits are moved verbatim.
- in_ready = EN && !flush && (count < DEPTH). There is no combinational path from out_ready.
- out_valid = EN && (count != 0). out_data/out_to_fp/out_illegal show the head entry when valid, and 0 otherwise.
- Pop on out_valid && out_ready. A simultaneous push and pop leaves count unchanged.
- EN low: no push, no pop, entries retained, and outputs masked as above.
- flush: count←0 and pointers←0 at the edge. Flush overrides a simultaneous push or pop.

## Timing
- Latency is 1 cycle. An op accepted at edge N is visible on out_valid in the cycle after N when the FIFO was empty.
- Throughput is 1 op/cycle while the consumer keeps out_ready high.
- Once asserted, out_valid and head contents stay stable until popped, or until EN falls, flush, or RST.
- Full (count==DEPTH): in_ready low. It rises the cycle after a pop.
- Empty: out_valid low. A pop attempt is ignored.
- Pointers wrap modulo DEPTH. count is never decremented below 0 and never incremented above DEPTH.
- Reset values: in_ready 0 while RST low; out_valid 0; out_data 0; out_to_fp 0; out_illegal 0; count 0.
- Reset asserted mid-operation discards all queued entries immediately and asynchronously.

## Structure
- Package fp_move_pkg:
  - op encoding enum (FMV_W_X, FMV_X_W, FMV_D_X, FMV_X_D)
  - NAN_BOX constant
  - entry struct {data, to_fp, illegal}
- Sub-module fp_move_fifo: generic DEPTH-entry synchronous FIFO of the entry struct, with count, flush and EN-gated push/pop.
- Top level contains the combinational move/box/extend logic and the handshake glue.

## Test plan
- FMV.W.X, rs_int=64'hC0CC_CCCC_C169_6042, out_ready=1 → next cycle: out_data=64'hFFFF_FFFF_C169_6042, out_to_fp=1.
- FMV.X.W, rs_fp=64'hFFFF_FFFF_C0CC_CCCD → 64'hFFFF_FFFF_C0CC_CCCD. Then rs_fp=64'h0000_0000_40CC_CCCD → 64'h0000_0000_40CC_CCCD, out_to_fp=0.
- Backpressure, DEPTH=2, out_ready=0:
  - Offer 3 ops (D.X 64'h1, D.X 64'h2, D.X 64'h3).
  - in_ready drops after 2 accepts and count=2.
  - Raise out_ready → outputs 1, 2 in order, then 3 is accepted and output.
- Simultaneous push and pop at count=1 → count stays 1 and order is preserved. flush with 2 queued → count=0 and out_valid=0 next cycle.
- Instance with FLEN=32, FMV.D.X → out_illegal=1 and out_data=0. FMV.W.X in the same instance yields rs_int[31:0] unboxed.
- RST low mid-stream with 2 entries queued and EN toggled → all outputs 0 immediately. After release, the first new op appears with 1-cycle latency.
